// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: frames bytes from the UART receiver into 5-byte command
// packets (HDR, CMD, DHI, DLO, CHK), validates the checksum, drops packets
// that stall between bytes, and presents the last good {cmd, data}.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | hunting for the header byte; non-header bytes are dropped
// CMD   | header seen, waiting for the command byte
// DHI   | waiting for the payload high byte
// DLO   | waiting for the payload low byte
// CHK   | waiting for the checksum byte; commit or report error
module uart_cmd_ctrl #(
  parameter logic [7:0] HDR       = 8'hAA,
  parameter int         TO_CYCLES = 260400,
  parameter int         TO_W      = 19
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        chk_err,
  output logic        to_err,
  output logic        ovr_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_DHI  = 3'd2,
    S_DLO  = 3'd3,
    S_CHK  = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [TO_W-1:0] timer;
  logic [7:0]      cmd_s;
  logic [7:0]      dhi_s;
  logic [7:0]      dlo_s;
  logic [7:0]      sum;
  logic [7:0]      chk_sum;
  logic            timer_tc;
  logic            commit;
  logic            chk_fail;
  logic            timeout;

  // Terminal count of the inter-byte timer; a byte in the same cycle wins.
  assign timer_tc = (timer == TO_W'(TO_CYCLES - 1));
  assign chk_sum  = sum + rx_data;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next state: advance on each accepted byte, fall back to IDLE on timeout.
  always_comb begin
    state_nx = state;
    if (rx_rdy) begin
      case (state)
        S_IDLE:  state_nx = (rx_data == HDR) ? S_CMD : S_IDLE;
        S_CMD:   state_nx = S_DHI;
        S_DHI:   state_nx = S_DLO;
        S_DLO:   state_nx = S_CHK;
        S_CHK:   state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end else if (state != S_IDLE && timer_tc) begin
      state_nx = S_IDLE;
    end
  end

  // FSM outputs: byte consume strobe plus commit / error events.
  always_comb begin
    clr_rx_rdy = rx_rdy;
    commit     = 1'b0;
    chk_fail   = 1'b0;
    timeout    = 1'b0;
    if (rx_rdy && state == S_CHK) begin
      commit   = (chk_sum == 8'h00);
      chk_fail = (chk_sum != 8'h00);
    end
    if (!rx_rdy && state != S_IDLE && timer_tc) timeout = 1'b1;
  end

  // Inter-byte timer: counts only while a packet is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           timer <= '0;
    else if (rx_rdy || state_nx == S_IDLE) timer <= '0;
    else                                  timer <= timer + TO_W'(1);
  end

  // Staging registers and running checksum; cleared when a packet times out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_s <= 8'h00;
      dhi_s <= 8'h00;
      dlo_s <= 8'h00;
      sum   <= 8'h00;
    end else if (timeout) begin
      cmd_s <= 8'h00;
      dhi_s <= 8'h00;
      dlo_s <= 8'h00;
      sum   <= 8'h00;
    end else if (rx_rdy) begin
      case (state)
        S_CMD: begin
          cmd_s <= rx_data;
          sum   <= rx_data;
        end
        S_DHI: begin
          dhi_s <= rx_data;
          sum   <= chk_sum;
        end
        S_DLO: begin
          dlo_s <= rx_data;
          sum   <= chk_sum;
        end
        default: ;
      endcase
    end
  end

  // Committed outputs; a commit beats a simultaneous consumer acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd     <= 8'h00;
      data    <= 16'h0000;
      cmd_rdy <= 1'b0;
      chk_err <= 1'b0;
      to_err  <= 1'b0;
      ovr_err <= 1'b0;
    end else begin
      chk_err <= chk_fail;
      to_err  <= timeout;
      ovr_err <= commit & cmd_rdy;
      if (commit) begin
        cmd     <= cmd_s;
        data    <= {dhi_s, dlo_s};
        cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed packet scenarios plus randomized traffic,
// checked every cycle against a packet-level reference model.
module tb_uart_cmd_ctrl;

  localparam logic [7:0] HDR = 8'hAA;
  localparam int TO_CYCLES = 40;
  localparam int TO_W      = 6;

  logic        clk;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        chk_err;
  logic        to_err;
  logic        ovr_err;

  int checks = 0;
  int errors = 0;
  int n_sent = 0;
  int n_clr  = 0;

  uart_cmd_ctrl #(.HDR(HDR), .TO_CYCLES(TO_CYCLES), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .data(data), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .chk_err(chk_err), .to_err(to_err),
    .ovr_err(ovr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packet as a byte queue, gap as count of byteless cycles.
  logic [7:0]  q[$];
  int          gap;
  logic [7:0]  m_cmd;
  logic [15:0] m_data;
  logic        m_rdy, m_chk, m_to, m_ovr;

  initial begin
    q.delete(); gap = 0;
    m_cmd = 0; m_data = 0; m_rdy = 0; m_chk = 0; m_to = 0; m_ovr = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete(); gap = 0;
        m_cmd = 0; m_data = 0; m_rdy = 0; m_chk = 0; m_to = 0; m_ovr = 0;
      end else begin
        logic good;
        good = 1'b0;
        m_chk = 0; m_to = 0; m_ovr = 0;
        if (rx_rdy) begin
          gap = 0;
          if (q.size() == 0) begin
            if (rx_data == HDR) q.push_back(rx_data);
          end else begin
            q.push_back(rx_data);
            if (q.size() == 5) begin
              int s;
              s = (int'(q[1]) + int'(q[2]) + int'(q[3]) + int'(q[4])) % 256;
              if (s == 0) begin
                good   = 1'b1;
                m_ovr  = m_rdy;
                m_cmd  = q[1];
                m_data = {q[2], q[3]};
              end else begin
                m_chk = 1'b1;
              end
              q.delete();
            end
          end
        end else if (q.size() != 0) begin
          gap++;
          if (gap == TO_CYCLES) begin
            m_to = 1'b1;
            q.delete();
            gap = 0;
          end
        end
        if (good) m_rdy = 1'b1;
        else if (clr_cmd_rdy) m_rdy = 1'b0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("clr_rx_rdy", clr_rx_rdy, rx_rdy);
    chk("cmd", cmd, m_cmd);
    chk("data", data, m_data);
    chk("cmd_rdy", cmd_rdy, m_rdy);
    chk("chk_err", chk_err, m_chk);
    chk("to_err", to_err, m_to);
    chk("ovr_err", ovr_err, m_ovr);
    if (rst_n && clr_rx_rdy) n_clr++;
  end

  // Called at posedge+1; presents one byte for exactly one cycle.
  task automatic send(input logic [7:0] b);
    rx_rdy  = 1'b1;
    rx_data = b;
    n_sent++;
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] dh,
                            input logic [7:0] dl, input logic [7:0] k);
    send(HDR); send(c); send(dh); send(dl); send(k);
  endtask

  task automatic ack;
    clr_cmd_rdy = 1'b1;
    idle(1);
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_rdy", cmd_rdy, 1'b0);
    chk("rst_data", data, 16'h0000);
    rst_n = 1'b1;
    idle(2);

    // T1
    send_frame(8'h05, 8'h12, 8'h34, 8'hB5);
    chk("t1_cmd", cmd, 8'h05);
    chk("t1_data", data, 16'h1234);
    chk("t1_rdy", cmd_rdy, 1'b1);
    chk("t1_errs", {chk_err, to_err, ovr_err}, 3'b000);
    idle(2);

    // T2: bad checksum keeps previous outputs
    send_frame(8'h05, 8'h12, 8'h34, 8'hB6);
    chk("t2_chk_err", chk_err, 1'b1);
    chk("t2_cmd", cmd, 8'h05);
    chk("t2_rdy", cmd_rdy, 1'b1);
    idle(1);
    chk("t2_pulse_end", chk_err, 1'b0);
    ack();
    chk("t2_ack", cmd_rdy, 1'b0);

    // T3: leading junk dropped
    send(8'h7F); send(8'h00);
    send_frame(8'h01, 8'h00, 8'h00, 8'hFF);
    chk("t3_cmd", cmd, 8'h01);
    chk("t3_data", data, 16'h0000);
    chk("t3_rdy_no_ovr", {cmd_rdy, ovr_err}, 2'b10);
    idle(2);

    // T4: timeout boundary
    send(HDR); send(8'h05);
    idle(TO_CYCLES - 1);
    chk("t4_to_early", to_err, 1'b0);
    idle(1);
    chk("t4_to_err", to_err, 1'b1);
    idle(1);
    send_frame(8'h05, 8'h12, 8'h34, 8'hB5);
    chk("t4_after_cmd", cmd, 8'h05);
    idle(1);

    // Byte arriving on the terminal-count cycle wins
    send(HDR); send(8'h07);
    idle(TO_CYCLES - 1);
    send(8'h12);
    chk("tc_byte_wins", to_err, 1'b0);
    send(8'h34); send(8'hB3);
    chk("tc_cmd", cmd, 8'h07);
    idle(1);

    // T5: overrun, then overrun coinciding with ack
    ack();
    send_frame(8'h05, 8'h12, 8'h34, 8'hB5);
    send_frame(8'h02, 8'h00, 8'h01, 8'hFD);
    chk("t5_ovr", ovr_err, 1'b1);
    chk("t5_cmd", cmd, 8'h02);
    chk("t5_data", data, 16'h0001);
    idle(1);
    send(HDR); send(8'h02); send(8'h00); send(8'h01);
    clr_cmd_rdy = 1'b1;
    send(8'hFD);
    clr_cmd_rdy = 1'b0;
    chk("t5_commit_wins", {cmd_rdy, ovr_err}, 2'b11);
    idle(1);

    // T6: reset mid-packet
    send(HDR); send(8'h05); send(8'h12);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", {cmd, data, cmd_rdy, chk_err, to_err, ovr_err}, 29'h0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send(8'h34); send(8'hB5);
    chk("t6_partial_lost", cmd_rdy, 1'b0);
    send_frame(8'h05, 8'h12, 8'h34, 8'hB5);
    chk("t6_cmd", cmd, 8'h05);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      int kind, s;
      logic [7:0] c, dh, dl, k;
      logic [7:0] b[5];
      kind = $urandom_range(0, 5);
      c = 8'($urandom); dh = 8'($urandom); dl = 8'($urandom);
      s = (int'(c) + int'(dh) + int'(dl)) % 256;
      k = 8'((256 - s) % 256);
      if (kind == 1) k = k ^ 8'($urandom_range(1, 255));
      b[0] = HDR; b[1] = c; b[2] = dh; b[3] = dl; b[4] = k;
      if (kind == 0) begin
        clr_cmd_rdy = ($urandom_range(0, 3) == 0);
        send(8'($urandom));
      end else begin
        for (int j = 0; j < 5; j++) begin
          int g;
          g = $urandom_range(0, 2);
          if (kind == 2 && j == 3) g = TO_CYCLES - 2 + $urandom_range(0, 3);
          clr_cmd_rdy = ($urandom_range(0, 3) == 0);
          if (g > 0) idle(g);
          send(b[j]);
        end
      end
      clr_cmd_rdy = 1'b0;
      idle($urandom_range(1, 3));
    end

    idle(2);
    chk("clr_count", n_clr, n_sent);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
